servo_seq: RTL
==============

# servo_seq

Sequencer that plays a stored servo trajectory. It steps an address counter through a synchronous-read position ROM at a programmable rate and absorbs the ROM's one-cycle read latency. It presents each fetched position, held stable, to the downstream servo PWM generator. It sits directly upstream of the generic ROM (drives its address and consumes its data) and feeds the PWM stage.

## Interface
- AW, 6: ROM address width.
- DW, 8: position/data width.
- LEN, 2**AW: number of ROM entries played, from address 0 to LEN-1; legal range 1..2**AW.
- TICKS, 1200000: step period in clk cycles (100 ms at 12 MHz); legal minimum 3.
- HOME, 8'h80: value `pos` takes at reset (servo centre).
- clk  in  1  system clock; everything is on its rising edge.
- rstn  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin playback from address 0.
- stop  in  1  single-cycle request to abort playback.
- loop  in  1  1 = wrap to address 0 after LEN-1; 0 = finish after LEN-1.
- rom_addr  out  AW  address to the ROM.
- rom_data  in  DW  ROM output; valid one cycle after `rom_addr` is sampled.
- pos  out  DW  current servo position, held between steps.
- pos_valid  out  1  one-cycle pulse on every `pos` update.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when non-looping playback completes.

## Operation
- States: IDLE, ADDR, WAIT, HOLD.
- IDLE:
  - On `start`=1 and `stop`=0: `rom_addr`<=0, go to ADDR.
  - If `start` and `stop` are both high, `stop` wins and the block stays in IDLE.
- ADDR: `rom_addr` is stable and sampled by the ROM. Next state is WAIT.
- WAIT: next edge does `pos`<=`rom_data`, `pos_valid`<=1, hold counter <= TICKS-3, and goes to HOLD.
- HOLD: the counter decrements each cycle. At 0 the block advances:
  - `rom_addr` < LEN-1: `rom_addr`+1, go to ADDR.
  - `rom_addr` = LEN-1 and `loop`=1: `rom_addr`<=0, go to ADDR.
  - `rom_addr` = LEN-1 and `loop`=0: go to IDLE, `done`<=1 for one cycle, `rom_addr` unchanged.
- `loop` is sampled only at the wrap decision.
- `stop` in any non-IDLE state: next state is IDLE. `pos` keeps its last value, no `pos_valid`, no `done`. A WAIT capture pending in the same cycle is dropped.
- `start` while `busy` is ignored.
- Counter width is $clog2(TICKS). Address arithmetic is AW bits; the LEN-1 comparison uses full width, so there is no implicit wrap when LEN < 2**AW.

## Timing
- Reset (rstn=0 at an edge) gives: state IDLE, `rom_addr`=0, `pos`=HOME, `pos_valid`=0, `busy`=0, `done`=0, counter=0.
- Reset overrides every other input, including mid-step.
- Latency from the `start` edge:
  - `busy` high 1 cycle later.
  - `pos` = rom[0] and `pos_valid` pulse 3 cycles later (IDLE→ADDR→WAIT→HOLD).
- Step period: consecutive `pos_valid` pulses are exactly TICKS cycles apart: TICKS-2 HOLD cycles + ADDR + WAIT.
- `pos` changes only on the edge that raises `pos_valid`.
- `done` and the `busy` fall occur on the same edge, TICKS-2 cycles after the last `pos_valid`.
- A new `start` is accepted on the cycle after `done`.

## Structure
- Shared package `servo_pkg`: state encodings (2-bit, IDLE=0), the HOME default, and the default TICKS constant for a 12 MHz clock.
- One natural sub-module, `seq_timer`: a loadable down-counter with a zero flag, parameterised by TICKS.
- The FSM, address counter and output registers live in `servo_seq`.

## Test plan
Bench configuration: AW=3, LEN=4, TICKS=5, ROM = {10,20,30,40,...}.
- Reset then idle → `pos`=8'h80, `busy`=0, `rom_addr`=0, no `pos_valid` for 20 cycles.
- `start` pulse, `loop`=0 →
  - `pos_valid` at cycles 3, 8, 13, 18 with `pos` 10, 20, 30, 40.
  - `done` and `busy`=0 at cycle 21.
  - `pos` stays 40.
- `loop`=1 → after 40 the next `pos_valid` is 5 cycles later with `pos`=10 and `rom_addr` wraps to 0. Dropping `loop` to 0 mid-sequence ends the run after 40.
- `stop` during WAIT of step 2 → IDLE next cycle, `pos` remains 10, no `pos_valid`, no `done`.
- `start` while busy → ignored, period unchanged. `start`+`stop` together in IDLE → stays IDLE.
- `rstn`=0 during HOLD → next cycle all outputs at reset values. A following `start` replays from 10.

Source files
------------

// File: rtl/servo_pkg.sv
// servo_pkg: definitions shared by the servo trajectory sequencer.
//   state_t     - sequencer state encoding (2-bit, IDLE = 0)
//   HOME_POS    - servo centre position loaded at reset
//   TICKS_12MHZ - default step period (100 ms at a 12 MHz clock)
package servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [7:0] HOME_POS    = 8'h80;
  localparam int         TICKS_12MHZ = 1200000;

endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter with a zero flag.
// Ports:
//   clk   in  - system clock, rising edge
//   rstn  in  - synchronous active-low reset (count -> 0)
//   load  in  - load TICKS-3 (has priority over dec)
//   dec   in  - decrement by one
//   zero  out - count is zero
module seq_timer
  import servo_pkg::*;
#(
  parameter int TICKS = TICKS_12MHZ
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = $clog2(TICKS);
  // ADDR and WAIT take two of the TICKS cycles; the count-zero HOLD cycle is the third.
  localparam logic [CW-1:0] LOAD_VAL = CW'(TICKS - 3);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next-count selection: load, decrement or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec) begin
      cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/servo_seq.sv
// servo_seq: plays a stored servo trajectory from a synchronous-read ROM.
// Steps rom_addr from 0 to LEN-1 once every TICKS cycles, absorbing the
// ROM's one-cycle read latency, and presents each fetched value on pos.
// Ports:
//   clk, rstn          - clock, synchronous active-low reset
//   start, stop        - single-cycle playback begin / abort requests
//   loop               - wrap to address 0 after LEN-1 instead of finishing
//   rom_addr, rom_data - ROM address out, ROM data in (valid one cycle later)
//   pos, pos_valid     - held position and its one-cycle update pulse
//   busy, done         - not idle; one-cycle end-of-playback pulse
module servo_seq
  import servo_pkg::*;
#(
  parameter int            AW    = 6,
  parameter int            DW    = 8,
  parameter int            LEN   = 2**AW,
  parameter int            TICKS = TICKS_12MHZ,
  parameter logic [DW-1:0] HOME  = HOME_POS
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] pos,
  output logic          pos_valid,
  output logic          busy,
  output logic          done
);

  // Full-width compare: no implicit wrap when LEN < 2**AW.
  localparam logic [AW-1:0] LAST_ADDR = AW'(LEN - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [DW-1:0] pos_q, pos_d;
  logic          pos_valid_q, pos_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timer_load, timer_dec, timer_zero;

  seq_timer #(
    .TICKS (TICKS)
  ) u_timer (
    .clk  (clk),
    .rstn (rstn),
    .load (timer_load),
    .dec  (timer_dec),
    .zero (timer_zero)
  );

  // Next-state, address and output computation.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    pos_d       = pos_q;
    pos_valid_d = 1'b0;
    done_d      = 1'b0;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // stop beats a simultaneous start
        if (start && !stop) begin
          rom_addr_d = {AW{1'b0}};
          state_d    = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // a stop here discards the capture that would happen on this edge
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          pos_d       = rom_data;
          pos_valid_d = 1'b1;
          timer_load  = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (!timer_zero) begin
          timer_dec = 1'b1;
        end else if (rom_addr_q != LAST_ADDR) begin
          rom_addr_d = rom_addr_q + {{(AW-1){1'b0}}, 1'b1};
          state_d    = ST_ADDR;
        end else if (loop) begin
          rom_addr_d = {AW{1'b0}};
          state_d    = ST_ADDR;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      rom_addr_q  <= {AW{1'b0}};
      pos_q       <= HOME;
      pos_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      pos_q       <= pos_d;
      pos_valid_q <= pos_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pos       = pos_q;
  assign pos_valid = pos_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
